pc_fetch_sequencer: RTL

//  Parametrised successor to the plain PC register. Owns the program counter and drives the

---
 rtl/pc_fetch_sequencer_pkg.sv | 6 +
 rtl/pc_fetch_sequencer_next_mux.sv | 20 ++
 rtl/pc_fetch_sequencer.sv | 87 ++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// pc_fetch_sequencer_pkg: shared fetch FSM states and instruction-size defaults.
package pc_fetch_sequencer_pkg;
    typedef enum logic [2:0] {BOOT, REQ, WAIT, DRAIN, HOLD} fetch_state_e;
    localparam int ILEN_BYTES_DEF = 4;
    localparam int ALIGN_W_DEF = $clog2(ILEN_BYTES_DEF);
endpackage

// File: rtl/pc_fetch_sequencer_next_mux.sv
// pc_next_mux: next fetch target select (trap > redirect > sequential) plus misalignment check.
module pc_next_mux
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int ILEN_BYTES = ILEN_BYTES_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic            trap,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);
    localparam logic [XLEN-1:0] MASK = XLEN'(ILEN_BYTES - 1);
    assign misaligned = !trap && redirect_valid && |(redirect_pc & MASK);
    assign target = (trap || misaligned) ? TRAP_VECTOR :
                    redirect_valid ? redirect_pc : pc + XLEN'(ILEN_BYTES);
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: program counter owner driving the I-cache handshake and holding fetched instructions for decode.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int ILEN_BYTES = ILEN_BYTES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    output logic            icache_req_valid_o,
    output logic [XLEN-1:0] icache_req_addr_o,
    input  logic            icache_req_ready_i,
    input  logic            icache_resp_valid_i,
    input  logic [31:0]     icache_resp_instr_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] pc_o,
    output logic            misaligned_o
);
    fetch_state_e state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] target;
    logic mis;
    logic ev;
    pc_next_mux #(
        .XLEN(XLEN),
        .TRAP_VECTOR(TRAP_VECTOR),
        .ILEN_BYTES(ILEN_BYTES)
    ) u_next (
        .pc(pc_q),
        .trap(trap_i),
        .redirect_valid(redirect_valid_i),
        .redirect_pc(redirect_pc_i),
        .target(target),
        .misaligned(mis)
    );
    // BOOT is the only state that lets control events pass unnoticed
    assign ev = (trap_i || redirect_valid_i) && state != BOOT;
    assign icache_req_valid_o = state == REQ;
    assign icache_req_addr_o = pc_q;
    assign pc_o = pc_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            pc_q <= RESET_VECTOR;
            instr_valid_o <= 1'b0;
            instr_o <= '0;
            instr_pc_o <= '0;
            misaligned_o <= 1'b0;
        end else begin
            misaligned_o <= mis && ev;
            if (ev || (state == WAIT && icache_resp_valid_i))
                pc_q <= target;
            case (state)
                BOOT: state <= REQ;
                REQ: if (!ev && icache_req_ready_i) state <= WAIT;
                WAIT: begin
                    if (icache_resp_valid_i) begin
                        state <= ev ? REQ : HOLD;
                        if (!ev) begin
                            instr_valid_o <= 1'b1;
                            instr_o <= icache_resp_instr_i;
                            instr_pc_o <= pc_q;
                        end
                    end else if (ev) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: if (icache_resp_valid_i) state <= REQ;
                HOLD: begin
                    if (ev || !stall_i) begin
                        state <= REQ;
                        instr_valid_o <= 1'b0;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule
